// File: rtl/result_writer_pkg.sv
// Shared constants and state encoding for the result-writer overlay blocks.
package result_writer_pkg;

    localparam int unsigned IMG_W    = 200;
    localparam int unsigned IMG_H    = 200;
    localparam int unsigned ADDR_MAX = IMG_W * IMG_H - 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_TOP    = 3'd1,
        ST_BOTTOM = 3'd2,
        ST_LEFT   = 3'd3,
        ST_RIGHT  = 3'd4,
        ST_FIN    = 3'd5
    } state_e;

endpackage

// File: rtl/rect_addr_gen.sv
// Linear frame-buffer address row*IMG_W+col; IMG_W is constant so this folds to shifts and adds.
module rect_addr_gen #(
    parameter int unsigned WIDTH_ADDR  = 16,
    parameter int unsigned WIDTH_COORD = 8,
    parameter int unsigned IMG_W       = 200
) (
    input  logic [WIDTH_COORD-1:0] row_i,
    input  logic [WIDTH_COORD-1:0] col_i,
    output logic [WIDTH_ADDR-1:0]  addr_o
);

    assign addr_o = WIDTH_ADDR'(WIDTH_ADDR'(row_i) * WIDTH_ADDR'(IMG_W)) + WIDTH_ADDR'(col_i);

endmodule

// File: rtl/rect_border_writer.sv
// Writes the four edges of one rectangle into the source frame BRAM, one pixel per clock,
// then pulses done so the frame copy can start.
module rect_border_writer #(
    parameter int unsigned WIDTH_ADDR  = 16,
    parameter int unsigned WIDTH_DATA  = 4,
    parameter int unsigned WIDTH_COORD = 8,
    parameter int unsigned IMG_W       = result_writer_pkg::IMG_W,
    parameter int unsigned IMG_H       = result_writer_pkg::IMG_H
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [WIDTH_COORD-1:0] x0,
    input  logic [WIDTH_COORD-1:0] x1,
    input  logic [WIDTH_COORD-1:0] y0,
    input  logic [WIDTH_COORD-1:0] y1,
    input  logic [WIDTH_DATA-1:0]  color,
    output logic [WIDTH_ADDR-1:0]  addr,
    output logic [WIDTH_DATA-1:0]  dout,
    output logic                   en,
    output logic                   we,
    output logic                   clkout,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    import result_writer_pkg::*;

    state_e                 state_q, state_d;
    logic [WIDTH_COORD-1:0] row_q, row_d, col_q, col_d;
    logic [WIDTH_COORD-1:0] x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
    logic [WIDTH_DATA-1:0]  color_q, color_d;
    logic [WIDTH_ADDR-1:0]  addr_q, addr_d;
    logic [WIDTH_DATA-1:0]  dout_q, dout_d;
    logic                   we_q, we_d, done_q, done_d, err_q, err_d;

    logic                   idle_c, box_ok_c, emit_c;
    state_e                 walk_st_c;
    logic [WIDTH_COORD-1:0] pix_row_c, pix_col_c, bx0_c, bx1_c, by0_c, by1_c;
    logic [WIDTH_ADDR-1:0]  pix_addr_c;

    // In IDLE the first pixel and the edge bounds come straight from the request inputs.
    assign idle_c    = (state_q == ST_IDLE);
    assign walk_st_c = idle_c ? ST_TOP : state_q;
    assign pix_row_c = idle_c ? y0 : row_q;
    assign pix_col_c = idle_c ? x0 : col_q;
    assign bx0_c     = idle_c ? x0 : x0_q;
    assign bx1_c     = idle_c ? x1 : x1_q;
    assign by0_c     = idle_c ? y0 : y0_q;
    assign by1_c     = idle_c ? y1 : y1_q;
    assign box_ok_c  = (x0 <= x1) && (32'(x1) < IMG_W) && (y0 <= y1) && (32'(y1) < IMG_H);

    rect_addr_gen #(
        .WIDTH_ADDR (WIDTH_ADDR),
        .WIDTH_COORD(WIDTH_COORD),
        .IMG_W      (IMG_W)
    ) u_addr_gen (
        .row_i (pix_row_c),
        .col_i (pix_col_c),
        .addr_o(pix_addr_c)
    );

    // Next state: row/col always hold the pixel to be presented at the next edge.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        x0_d    = x0_q;
        x1_d    = x1_q;
        y0_d    = y0_q;
        y1_d    = y1_q;
        color_d = color_q;
        addr_d  = addr_q;
        dout_d  = '0;
        we_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        emit_c  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (box_ok_c) begin
                        x0_d    = x0;
                        x1_d    = x1;
                        y0_d    = y0;
                        y1_d    = y1;
                        color_d = color;
                        emit_c  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_TOP, ST_BOTTOM, ST_LEFT, ST_RIGHT: emit_c = 1'b1;
            ST_FIN: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (emit_c) begin
            we_d   = 1'b1;
            dout_d = color_d;
            addr_d = pix_addr_c;
            unique case (walk_st_c)
                ST_TOP: begin
                    if (pix_col_c == bx1_c) begin
                        state_d = ST_BOTTOM;
                        row_d   = by1_c;
                        col_d   = bx0_c;
                    end else begin
                        state_d = ST_TOP;
                        row_d   = pix_row_c;
                        col_d   = pix_col_c + WIDTH_COORD'(1);
                    end
                end
                ST_BOTTOM: begin
                    if (pix_col_c == bx1_c) begin
                        state_d = ST_LEFT;
                        row_d   = by0_c;
                        col_d   = bx0_c;
                    end else begin
                        state_d = ST_BOTTOM;
                        row_d   = pix_row_c;
                        col_d   = pix_col_c + WIDTH_COORD'(1);
                    end
                end
                ST_LEFT: begin
                    if (pix_row_c == by1_c) begin
                        state_d = ST_RIGHT;
                        row_d   = by0_c;
                        col_d   = bx1_c;
                    end else begin
                        state_d = ST_LEFT;
                        row_d   = pix_row_c + WIDTH_COORD'(1);
                        col_d   = pix_col_c;
                    end
                end
                ST_RIGHT: begin
                    if (pix_row_c == by1_c) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_RIGHT;
                        row_d   = pix_row_c + WIDTH_COORD'(1);
                        col_d   = pix_col_c;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            x0_q    <= '0;
            x1_q    <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            color_q <= '0;
            addr_q  <= '0;
            dout_q  <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            x0_q    <= x0_d;
            x1_q    <= x1_d;
            y0_q    <= y0_d;
            y1_q    <= y1_d;
            color_q <= color_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            we_q    <= we_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign addr   = addr_q;
    assign dout   = dout_q;
    assign en     = we_q;
    assign we     = we_q;
    assign busy   = we_q;
    assign done   = done_q;
    assign err    = err_q;
    assign clkout = ~clk;

endmodule
